act_vec_serializer: RTL and testbench

- Consumer of the parallel activation vector produced by the relu_config4 stage: 9 lanes × 32-bit ap_fixed<32,8>.
- Captures one whole vector per handshake and streams it out one element per beat over a valid/ready interface, with an index and a last marker.
- Feeds the time-multiplexed dense layer of the motorB network, which reads its input serially.
- Flags sticky diagnostics when an input element violates the ReLU post-condition (value must be ≥ 0).

---
 rtl/act_vec_serializer_if.sv | 26 ++
 rtl/act_vec_serializer.sv | 105 ++++++++++
 tb/tb_act_vec_serializer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/act_vec_serializer_if.sv
// Vector-in / element-out stream bundle for the activation serializer.
// The serializer takes the slave side; the producer/consumer pair uses master.
interface act_vec_serializer_if #(
  parameter int N    = 9,
  parameter int W    = 32,
  parameter int IDXW = 4
);
  logic [N*W-1:0]  in_data;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_idx;
  logic            out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_idx, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_idx, out_last
  );
endinterface

// File: rtl/act_vec_serializer.sv
// Captures a 9-lane ReLU activation vector and streams it one element per beat,
// lane 0 first, with sticky diagnostics for negative lanes and a frame counter.
module act_vec_serializer #(
  parameter int N    = 9,
  parameter int W    = 32,
  parameter int IDXW = 4
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  act_vec_serializer_if.slave  bus,
  input  logic                 clr_diag,
  output logic [15:0]          frame_cnt,
  output logic                 neg_seen
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_next;
  logic [IDXW-1:0] idx, idx_next;
  logic [N*W-1:0]  vec_p0;
  logic            load, frame_done, last_idx;

  function automatic logic any_neg(input logic [N*W-1:0] v);
    logic r;
    r = 1'b0;
    for (int k = 0; k < N; k++) r = r | v[k*W + W - 1];
    return r;
  endfunction

  function automatic logic [W-1:0] lane_sel(input logic [N*W-1:0] v, input logic [IDXW-1:0] i);
    return v[int'(i)*W +: W];
  endfunction

  assign last_idx = (idx == IDXW'(N - 1));

  // load/frame_done already include the handshakes, so the datapath never re-checks them
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    load         = 1'b0;
    frame_done   = 1'b0;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready & last_idx;
        if (bus.out_ready) begin
          if (!last_idx) begin
            idx_next = idx + IDXW'(1);
          end else begin
            frame_done = 1'b1;
            idx_next   = '0;
            if (bus.in_valid) load = 1'b1;
            else              state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // p0: captured vector, held untouched until the next accept
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  vec_p0 <= '0;
    else if (load)  vec_p0 <= bus.in_data;
  end

  assign bus.out_data = lane_sel(vec_p0, idx);
  assign bus.out_idx  = idx;
  assign bus.out_last = (state == SEND) & last_idx;

  // clear takes priority over same-cycle set/increment
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      frame_cnt <= '0;
      neg_seen  <= 1'b0;
    end else if (clr_diag) begin
      frame_cnt <= '0;
      neg_seen  <= 1'b0;
    end else begin
      if (frame_done)                  frame_cnt <= frame_cnt + 16'd1;
      if (load && any_neg(bus.in_data)) neg_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_act_vec_serializer.sv
// Bench for act_vec_serializer: table of vectors plus hand sequences for
// back-to-back, clear priority, mid-frame reset and counter wrap.
module tb_act_vec_serializer;
  localparam int N    = 9;
  localparam int W    = 32;
  localparam int IDXW = 4;

  typedef struct {
    logic [W-1:0]    d;
    logic [IDXW-1:0] idx;
    logic            last;
  } beat_t;

  typedef struct {
    logic [N*W-1:0] data;
    logic [31:0]    ready_pat;
    logic           exp_neg;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        clr_diag;
  logic [15:0] frame_cnt;
  logic        neg_seen;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int exp_frames = 0;

  beat_t sb[$];

  act_vec_serializer_if #(.N(N), .W(W), .IDXW(IDXW)) b();

  act_vec_serializer #(.N(N), .W(W), .IDXW(IDXW)) dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .bus       (b.slave),
    .clr_diag  (clr_diag),
    .frame_cnt (frame_cnt),
    .neg_seen  (neg_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] ramp(input int mul);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = 32'h100 * (k + 1) * mul;
    return v;
  endfunction

  // Reference model: every accepted vector becomes N expected beats
  logic            prev_stall;
  logic [W-1:0]    held_d;
  logic [IDXW-1:0] held_idx;
  logic            held_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && b.out_valid) begin
        chk("hold_data", b.out_data, held_d);
        chk("hold_idx",  b.out_idx,  held_idx);
        chk("hold_last", b.out_last, held_last);
      end
      if (b.out_valid && b.out_ready) begin
        beats++;
        if (sb.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_data", b.out_data, e.d);
          chk("beat_idx",  b.out_idx,  e.idx);
          chk("beat_last", b.out_last, e.last);
        end
      end
      if (b.in_valid && b.in_ready) begin
        for (int k = 0; k < N; k++) begin
          beat_t e;
          e.d    = b.in_data[k*W +: W];
          e.idx  = IDXW'(k);
          e.last = (k == N - 1);
          sb.push_back(e);
        end
      end
      prev_stall = b.out_valid && !b.out_ready;
      held_d     = b.out_data;
      held_idx   = b.out_idx;
      held_last  = b.out_last;
    end
  end

  task automatic send_frame(input logic [N*W-1:0] d, input logic [31:0] pat);
    int c;
    @(posedge clk); #1;
    b.in_data = d; b.in_valid = 1'b1; b.out_ready = 1'b1;
    c = 0;
    while (!b.in_ready) begin
      @(posedge clk); #1; c++;
      if (c > 50) begin chk("accept_timeout", 0, 1); b.in_valid = 1'b0; return; end
    end
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    b.in_data  = '1;
    chk("in_ready_drop", b.in_ready, 0);
    c = 0;
    while (b.out_valid || sb.size() != 0) begin
      b.out_ready = pat[c % 32];
      @(posedge clk); #1; c++;
      if (c > 300) begin chk("frame_timeout", 0, 1); break; end
    end
    b.out_ready = 1'b1;
  endtask

  vec_t tbl[5];

  initial begin
    logic [N*W-1:0] v;
    int b0, c;

    v = '0; v[4*W +: W] = 32'hFFFFFF00;
    tbl[0] = '{ramp(1), 32'hFFFFFFFF, 1'b0};
    tbl[1] = '{ramp(2), 32'h49249249, 1'b0};
    tbl[2] = '{'0,      32'hFFFFFFFF, 1'b0};
    tbl[3] = '{v,       32'hFFFFFFFF, 1'b1};
    tbl[4] = '{{9{32'h1234_5678}} ^ ramp(3), 32'h5A5A5A5A, 1'b1};

    rst_n = 1'b0; clr_diag = 1'b0;
    b.in_data = '0; b.in_valid = 1'b0; b.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_in_ready",  b.in_ready,  1);
    chk("rst_out_idx",   b.out_idx,   0);
    chk("rst_out_last",  b.out_last,  0);
    chk("rst_out_data",  b.out_data,  0);
    chk("rst_frame_cnt", frame_cnt,   0);
    chk("rst_neg_seen",  neg_seen,    0);
    @(posedge clk); #1; rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, tbl[i].ready_pat);
      exp_frames++;
      chk("tbl_frame_cnt", frame_cnt, exp_frames);
      chk("tbl_neg_seen",  neg_seen,  tbl[i].exp_neg);
    end

    // clr_diag pulse clears both next cycle
    @(posedge clk); #1; clr_diag = 1'b1;
    @(posedge clk); #1; clr_diag = 1'b0;
    chk("clr_neg_seen",  neg_seen,  0);
    chk("clr_frame_cnt", frame_cnt, 0);
    exp_frames = 0;

    // clear coinciding with a negative-lane accept: clear wins
    b.in_data = v; b.in_valid = 1'b1; clr_diag = 1'b1; b.out_ready = 1'b1;
    @(posedge clk); #1;
    b.in_valid = 1'b0; clr_diag = 1'b0;
    chk("clr_wins_neg", neg_seen, 0);
    c = 0;
    while (b.out_valid && c < 50) begin @(posedge clk); #1; c++; end
    exp_frames++;
    chk("clr_wins_frames", frame_cnt, exp_frames);

    // back-to-back: 18 beats in 18 cycles
    b0 = beats;
    b.in_data = ramp(1); b.in_valid = 1'b1; b.out_ready = 1'b1;
    @(posedge clk); #1;
    b.in_data = ramp(4);
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      if (k == 8) b.in_valid = 1'b0;
    end
    chk("b2b_beats", beats - b0, 18);
    chk("b2b_drain", b.out_valid, 0);
    exp_frames += 2;
    chk("b2b_frames", frame_cnt, exp_frames);

    // async reset at out_idx 5
    b.in_data = ramp(1); b.in_valid = 1'b1;
    @(posedge clk); #1; b.in_valid = 1'b0;
    c = 0;
    while (b.out_idx != 4'd5 && c < 50) begin @(posedge clk); #1; c++; end
    chk("rst_mid_reached", b.out_idx, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid",  b.out_valid, 0);
    chk("rst_mid_ready",  b.in_ready,  1);
    chk("rst_mid_frames", frame_cnt,   0);
    @(posedge clk); #1; rst_n = 1'b1;
    send_frame(ramp(5), 32'hFFFFFFFF);
    chk("post_rst_frames", frame_cnt, 1);

    // wrap 65535 -> 0
    @(negedge clk); force dut.frame_cnt = 16'hFFFF;
    @(negedge clk); release dut.frame_cnt;
    #1;
    chk("wrap_preload", frame_cnt, 16'hFFFF);
    send_frame(ramp(6), 32'hFFFFFFFF);
    chk("wrap_frame_cnt", frame_cnt, 0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
